aabb_sweep_scheduler: RTL and testbench

Per-ray closest-hit sequencer for the primitive unit's single AABB test datapath. Accepts one tagged ray, walks a box table of up to BOX_COUNT entries through a synchronous read port, issues one ray/box test at a time to the AABB unit, filters its results, and returns the nearest hit (index, tmin, box, tag). A watchdog bounds each test so a stalled unit never hangs the ray pipeline.

---
 rtl/aabb_sweep_scheduler_if.sv | 45 ++++
 rtl/aabb_sweep_scheduler.sv | 154 +++++++++++++++
 tb/tb_aabb_sweep_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aabb_sweep_scheduler_if.sv
// aabb_sweep_scheduler_if: groups the ray, box-table, AABB-unit and result signals of the sweep scheduler
// Field layouts (flat vectors, MSB first):
//   ray    = {origin xyz, direction xyz, tag}    6*WIDTH + TAG_SIZE bits
//   box    = {min xyz, max xyz}                  6*WIDTH bits
//   result = {ray_hit, tmin, tag}                1 + WIDTH + TAG_SIZE bits
// slave modport is the scheduler side, master modport is the environment side.
interface aabb_sweep_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int TAG_SIZE = 4,
  parameter int IDX_W = 4
);
  localparam int RAY_W = 6 * WIDTH + TAG_SIZE;
  localparam int BOX_W = 6 * WIDTH;
  localparam int RES_W = 1 + WIDTH + TAG_SIZE;
  logic ray_valid;
  logic ray_ready;
  logic [RAY_W-1:0] ray_in;
  logic [IDX_W:0] num_boxes;
  logic box_rd_en;
  logic [IDX_W-1:0] box_addr;
  logic [BOX_W-1:0] box_data;
  logic aabb_start;
  logic [RAY_W-1:0] aabb_ray;
  logic [BOX_W-1:0] aabb_box;
  logic aabb_valid;
  logic [RES_W-1:0] aabb_result;
  logic out_valid;
  logic out_ready;
  logic hit;
  logic [IDX_W-1:0] hit_index;
  logic [WIDTH-1:0] hit_tmin;
  logic [BOX_W-1:0] hit_box;
  logic [TAG_SIZE-1:0] hit_tag;
  logic timeout_err;
  modport slave (
    input ray_valid, ray_in, num_boxes, box_data, aabb_valid, aabb_result, out_ready,
    output ray_ready, box_rd_en, box_addr, aabb_start, aabb_ray, aabb_box,
    output out_valid, hit, hit_index, hit_tmin, hit_box, hit_tag, timeout_err
  );
  modport master (
    output ray_valid, ray_in, num_boxes, box_data, aabb_valid, aabb_result, out_ready,
    input ray_ready, box_rd_en, box_addr, aabb_start, aabb_ray, aabb_box,
    input out_valid, hit, hit_index, hit_tmin, hit_box, hit_tag, timeout_err
  );
endinterface

// File: rtl/aabb_sweep_scheduler.sv
// aabb_sweep_scheduler: per-ray closest-hit sequencer driving a single AABB test unit
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     slave side of aabb_sweep_scheduler_if: ray handshake, box table read port,
//           AABB unit start/result, closest-hit result handshake, timeout flag
module aabb_sweep_scheduler #(
  parameter int WIDTH = 16,
  parameter int Q_BITS = 8,
  parameter int TAG_SIZE = 4,
  parameter int BOX_COUNT = 16,
  parameter int IDX_W = $clog2(BOX_COUNT),
  parameter int TIMEOUT = 64,
  parameter logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}}
) (
  input logic clk_i,
  input logic rst_ni,
  aabb_sweep_scheduler_if.slave bus
);
  localparam int RAY_W = 6 * WIDTH + TAG_SIZE;
  localparam int BOX_W = 6 * WIDTH;
  localparam int RES_W = 1 + WIDTH + TAG_SIZE;
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W:0] N_MAX = (IDX_W + 1)'(BOX_COUNT);
  localparam logic [IDX_W:0] N_ONE = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  if (Q_BITS >= WIDTH || BOX_COUNT < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("aabb_sweep_scheduler: unsupported parameter set");
  end
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, NEXT, DONE} state_e;
  state_e state_q;
  logic [RAY_W-1:0] ray_q;
  logic [BOX_W-1:0] box_q;
  logic [IDX_W:0] n_q;
  logic [IDX_W-1:0] idx_q;
  logic [WD_W-1:0] wdog_q;
  logic hit_q;
  logic [IDX_W-1:0] hit_index_q;
  logic [WIDTH-1:0] hit_tmin_q;
  logic [BOX_W-1:0] hit_box_q;
  logic [TAG_SIZE-1:0] hit_tag_q;
  logic err_q;
  logic out_valid_q;
  logic aabb_start_q;
  logic box_rd_en_q;
  logic [IDX_W-1:0] box_addr_q;
  logic [IDX_W:0] n_clamp;
  logic res_ok;
  logic better;
  logic last;
  assign n_clamp = bus.num_boxes > N_MAX ? N_MAX : bus.num_boxes;
  // The unit's valid is registered, so whatever it shows in the first WAIT cycle
  // may belong to an earlier test; only results from the second cycle on count.
  assign res_ok = bus.aabb_valid && wdog_q != '0 && bus.aabb_result[TAG_SIZE-1:0] == ray_q[TAG_SIZE-1:0];
  // Strict less-than keeps the lower index on equal tmin.
  assign better = bus.aabb_result[RES_W-1] &&
                  (!hit_q || $signed(bus.aabb_result[TAG_SIZE +: WIDTH]) < $signed(hit_tmin_q));
  assign last = {1'b0, idx_q} == n_q - N_ONE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ray_q <= '0;
      box_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      wdog_q <= '0;
      hit_q <= 1'b0;
      hit_index_q <= '0;
      hit_tmin_q <= '0;
      hit_box_q <= '0;
      hit_tag_q <= '0;
      err_q <= 1'b0;
      out_valid_q <= 1'b0;
      aabb_start_q <= 1'b0;
      box_rd_en_q <= 1'b0;
      box_addr_q <= '0;
    end else begin
      aabb_start_q <= 1'b0;
      box_rd_en_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.ray_valid) begin
          ray_q <= bus.ray_in;
          hit_tag_q <= bus.ray_in[TAG_SIZE-1:0];
          n_q <= n_clamp;
          idx_q <= '0;
          hit_q <= 1'b0;
          hit_index_q <= '0;
          hit_tmin_q <= MAX;
          hit_box_q <= '0;
          err_q <= 1'b0;
          box_addr_q <= '0;
          box_rd_en_q <= n_clamp != '0;
          state_q <= n_clamp == '0 ? DONE : FETCH;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          box_q <= bus.box_data;
          aabb_start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          wdog_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wdog_q <= wdog_q + WD_ONE;
          if (res_ok) begin
            if (better) begin
              hit_q <= 1'b1;
              hit_index_q <= idx_q;
              hit_tmin_q <= bus.aabb_result[TAG_SIZE +: WIDTH];
              hit_box_q <= box_q;
            end
            state_q <= NEXT;
          end else if (wdog_q == WD_LAST) begin
            err_q <= 1'b1;
            state_q <= NEXT;
          end
        end
        NEXT: if (last) begin
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          idx_q <= idx_q + IDX_ONE;
          box_addr_q <= idx_q + IDX_ONE;
          box_rd_en_q <= 1'b1;
          state_q <= FETCH;
        end
        // An empty ray enters DONE with out_valid still low and raises it one cycle later.
        DONE: if (!out_valid_q) out_valid_q <= 1'b1;
        else if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ray_ready = state_q == IDLE;
  assign bus.box_rd_en = box_rd_en_q;
  assign bus.box_addr = box_addr_q;
  assign bus.aabb_start = aabb_start_q;
  assign bus.aabb_ray = ray_q;
  assign bus.aabb_box = box_q;
  assign bus.out_valid = out_valid_q;
  assign bus.hit = hit_q;
  assign bus.hit_index = hit_index_q;
  assign bus.hit_tmin = hit_tmin_q;
  assign bus.hit_box = hit_box_q;
  assign bus.hit_tag = hit_tag_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_aabb_sweep_scheduler.sv
// tb_aabb_sweep_scheduler: randomized and directed checks of the sweep scheduler against a per-ray reference model
module tb_aabb_sweep_scheduler;
  localparam int W = 16;
  localparam int TG = 4;
  localparam int BC = 16;
  localparam int IW = 4;
  localparam int TO = 8;
  localparam int RAY_W = 6 * W + TG;
  localparam int BOX_W = 6 * W;
  localparam logic [W-1:0] MAXV = 16'h7fff;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  aabb_sweep_scheduler_if #(.WIDTH(W), .TAG_SIZE(TG), .IDX_W(IW)) bus ();
  aabb_sweep_scheduler #(.WIDTH(W), .TAG_SIZE(TG), .BOX_COUNT(BC), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [BOX_W-1:0] box_mem [BC];
  int cfg_k [BC];
  logic cfg_hit [BC];
  logic [W-1:0] cfg_tmin [BC];
  logic cfg_stale [BC];
  logic cfg_wrong [BC];
  logic [RAY_W-1:0] cur_ray = '0;
  logic [TG-1:0] cur_tag = '0;
  int base = 0;
  int starts = 0;
  int model_errs = 0;
  int mi;
  int cd = 0;
  logic pend = 1'b0;
  logic m_hit = 1'b0;
  logic m_wrong = 1'b0;
  logic [W-1:0] m_tmin = '0;
  always @(posedge clk) if (bus.box_rd_en) bus.box_data <= box_mem[bus.box_addr];
  // AABB unit: answers k cycles after start (k==0: never), optionally emitting a stale
  // result in the blanked first wait cycle and a wrong-tag result in the next one.
  always @(posedge clk) begin
    bus.aabb_valid <= 1'b0;
    if (!rst_n) pend <= 1'b0;
    else if (bus.aabb_start) begin
      mi = starts - base;
      starts <= starts + 1;
      if (mi >= BC) model_errs <= model_errs + 1;
      else begin
        if (bus.aabb_ray != cur_ray || bus.aabb_box != box_mem[mi]) model_errs <= model_errs + 1;
        pend <= cfg_k[mi] != 0;
        cd <= cfg_k[mi] - 1;
        m_hit <= cfg_hit[mi];
        m_tmin <= cfg_tmin[mi];
        m_wrong <= cfg_wrong[mi];
        if (cfg_stale[mi]) begin
          bus.aabb_valid <= 1'b1;
          bus.aabb_result <= {1'b1, 16'h8000, cur_tag};
        end
      end
    end else if (pend) begin
      if (cd == 1) begin
        bus.aabb_valid <= 1'b1;
        bus.aabb_result <= {m_hit, m_tmin, cur_tag};
        pend <= 1'b0;
      end else begin
        cd <= cd - 1;
        if (m_wrong) begin
          bus.aabb_valid <= 1'b1;
          bus.aabb_result <= {1'b1, 16'h8000, cur_tag ^ 4'h1};
          m_wrong <= 1'b0;
        end
      end
    end
  end
  task automatic cfg_all(input int k, input logic h, input logic [W-1:0] t);
    for (int i = 0; i < BC; i++) begin
      cfg_k[i] = k;
      cfg_hit[i] = h;
      cfg_tmin[i] = t;
      cfg_stale[i] = 1'b0;
      cfg_wrong[i] = 1'b0;
    end
  endtask
  task automatic new_ray();
    for (int i = 0; i < BC; i++) box_mem[i] = {$urandom(), $urandom(), $urandom()};
    cur_ray = {$urandom(), $urandom(), $urandom(), 4'($urandom())};
    cur_tag = cur_ray[TG-1:0];
    base = starts;
  endtask
  task automatic accept(input int num);
    for (int t = 0; t < 20 && !bus.ray_ready; t++) @(negedge clk);
    check("ray_ready_idle", bus.ray_ready, 1);
    bus.ray_valid = 1'b1;
    bus.ray_in = cur_ray;
    bus.num_boxes = 5'(num);
    @(posedge clk);
  endtask
  task automatic run_ray(input int num, input int hold);
    int n, lat, exp_lat, best, b0, e0;
    logic exp_hit, exp_err, acc, got_ov;
    logic [W-1:0] exp_tmin;
    n = num > BC ? BC : num;
    exp_hit = 1'b0;
    exp_err = 1'b0;
    exp_tmin = MAXV;
    best = 0;
    exp_lat = n == 0 ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      acc = cfg_k[i] != 0 && cfg_k[i] <= TO;
      exp_lat += acc ? cfg_k[i] + 4 : TO + 4;
      if (!acc) exp_err = 1'b1;
      else if (cfg_hit[i] && (!exp_hit || $signed(cfg_tmin[i]) < $signed(exp_tmin))) begin
        exp_hit = 1'b1;
        best = i;
        exp_tmin = cfg_tmin[i];
      end
    end
    new_ray();
    b0 = starts;
    e0 = model_errs;
    accept(num);
    lat = 0;
    got_ov = 1'b0;
    while (lat < 1000 && !got_ov) begin
      @(negedge clk);
      bus.ray_valid = 1'b0;
      lat++;
      got_ov = bus.out_valid;
    end
    check("out_valid", got_ov, 1);
    check("latency", lat, exp_lat);
    check("hit", bus.hit, exp_hit);
    check("hit_tmin", bus.hit_tmin, exp_tmin);
    check("hit_index", bus.hit_index, exp_hit ? best : 0);
    check("hit_tag", bus.hit_tag, cur_tag);
    check("timeout_err", bus.timeout_err, exp_err);
    if (exp_hit) check("hit_box", bus.hit_box, box_mem[best]);
    check("start_pulses", starts - b0, n);
    check("unit_operands", model_errs - e0, 0);
    check("ray_ready_busy", bus.ray_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_tmin", bus.hit_tmin, exp_tmin);
      check("stall_index", bus.hit_index, exp_hit ? best : 0);
      check("stall_ready", bus.ray_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("drain_valid", bus.out_valid, 0);
    check("drain_ready", bus.ray_ready, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int s, num;
    bus.ray_valid = 1'b0;
    bus.ray_in = '0;
    bus.num_boxes = '0;
    bus.out_ready = 1'b0;
    cfg_all(5, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("rst_ray_ready", bus.ray_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_tmin", bus.hit_tmin, 0);
    check("rst_index", bus.hit_index, 0);
    check("rst_err", bus.timeout_err, 0);
    check("rst_start", bus.aabb_start, 0);
    check("rst_rd_en", bus.box_rd_en, 0);
    check("rst_addr", bus.box_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_all(5, 1'b0, '0);
    cfg_hit[1] = 1'b1;
    cfg_tmin[1] = 16'h0300;
    cfg_hit[3] = 1'b1;
    cfg_tmin[3] = 16'h0100;
    run_ray(4, 0);
    cfg_all(4, 1'b0, '0);
    cfg_hit[0] = 1'b1;
    cfg_tmin[0] = 16'h0200;
    cfg_hit[2] = 1'b1;
    cfg_tmin[2] = 16'h0200;
    run_ray(3, 1);
    cfg_all(3, 1'b0, 16'h0010);
    run_ray(5, 0);
    run_ray(0, 0);
    cfg_all(2, 1'b0, '0);
    cfg_hit[7] = 1'b1;
    cfg_tmin[7] = 16'hff00;
    run_ray(20, 0);
    cfg_all(5, 1'b0, '0);
    cfg_hit[0] = 1'b1;
    cfg_tmin[0] = 16'h0050;
    cfg_k[2] = 0;
    cfg_hit[2] = 1'b1;
    cfg_tmin[2] = 16'h0001;
    run_ray(3, 0);
    cfg_all(TO, 1'b0, '0);
    cfg_hit[1] = 1'b1;
    cfg_tmin[1] = 16'h0040;
    cfg_k[2] = TO + 1;
    cfg_hit[2] = 1'b1;
    cfg_tmin[2] = 16'h0002;
    run_ray(3, 2);
    cfg_all(6, 1'b0, '0);
    for (int i = 0; i < BC; i++) begin
      cfg_stale[i] = 1'b1;
      cfg_wrong[i] = 1'b1;
    end
    cfg_hit[1] = 1'b1;
    cfg_tmin[1] = 16'h0400;
    run_ray(3, 10);
    cfg_all(5, 1'b1, 16'h0100);
    new_ray();
    accept(3);
    repeat (5) begin
      @(negedge clk);
      bus.ray_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ray_ready", bus.ray_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_start", bus.aabb_start, 0);
    check("midrst_rd_en", bus.box_rd_en, 0);
    check("midrst_hit", bus.hit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_all(3, 1'b0, '0);
    cfg_hit[2] = 1'b1;
    cfg_tmin[2] = 16'hfe00;
    run_ray(4, 0);
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < BC; i++) begin
        s = $urandom_range(0, 9);
        cfg_k[i] = s == 0 ? 0 : (s == 1 ? TO + 1 + $urandom_range(0, 2) : $urandom_range(2, TO));
        cfg_hit[i] = 1'($urandom_range(0, 1));
        cfg_tmin[i] = 16'(int'($urandom_range(0, 7)) * 256 - 768);
        cfg_stale[i] = $urandom_range(0, 3) == 0;
        cfg_wrong[i] = $urandom_range(0, 3) == 0;
      end
      num = r % 7 == 0 ? $urandom_range(0, 20) : $urandom_range(1, 5);
      run_ray(num, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
